hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Hazard and sequencing controller for the five-stage RV32IM pipeline.
- Drives the stall, flush and forwarding controls for the IF/ID and ID/EX pipeline registers.
- Detects load-use hazards and resolves branch/jump redirects.
- Holds a DIV/REM instruction in EX for a fixed multi-cycle latency using a small FSM and a down-counter.

Parameters:
- DIV_LAT, 4: total EX-stage cycles occupied by a DIV/DIVU/REM/REMU. Legal range is 2..16.
- CNT_W, 4: width of the internal divide cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rs1D  in  5  source register 1 of the instruction in ID.
- rs2D  in  5  source register 2 of the instruction in ID.
- rs1E  in  5  source register 1 of the instruction in EX.
- rs2E  in  5  source register 2 of the instruction in EX.
- rdE  in  5  destination register of the instruction in EX.
- MemtoRegE  in  1  instruction in EX is a load.
- DivOpE  in  1  instruction in EX is DIV/DIVU/REM/REMU.
- PCSrcE  in  1  branch taken or jump resolved in EX.
- rdM  in  5  destination register in MEM.
- RegWriteM  in  1  MEM instruction writes the register file.
- rdW  in  5  destination register in WB.
- RegWriteW  in  1  WB instruction writes the register file.
- StallF  out  1  hold the PC.
- StallD  out  1  hold IF/ID.
- StallE  out  1  hold ID/EX.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  clear ID/EX control fields to a bubble.
- ForwardAE  out  2  ALU operand A select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE.
- div_busy  out  1  a divide is occupying EX.
- div_done  out  1  divide result is valid this cycle; selects the divider output in EX.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, counter = 0.
  - Every output is forced to 0 while reset is low, including all combinational outputs.
  - Reset in the middle of a divide aborts it immediately; div_done does not pulse.
- Forwarding (combinational, same cycle):
  - ForwardAE = 10 if RegWriteM && rdM != 0 && rdM == rs1E.
  - Otherwise ForwardAE = 01 if RegWriteW && rdW != 0 && rdW == rs1E.
  - Otherwise ForwardAE = 00.
  - MEM has priority over WB. ForwardBE is identical, using rs2E.
- Load-use: lwStall = MemtoRegE && rdE != 0 && (rdE == rs1D || rdE == rs2D).
- Divide FSM, states IDLE, BUSY, DONE:
  - IDLE with DivOpE = 1 (entry cycle): load counter = DIV_LAT-2. Next state is DONE if DIV_LAT == 2, otherwise BUSY.
  - BUSY: decrement the counter each cycle. When counter == 1, next state is DONE.
  - DONE: div_done = 1 for exactly one cycle, then unconditionally IDLE. The divide advances to MEM on this edge, so there is no retrigger.
  - EX occupancy is exactly DIV_LAT cycles.
- Divide stall: divStall = (IDLE && DivOpE) || BUSY.
  - div_busy = divStall.
  - divStall is deasserted in DONE.
- Stall and flush equations:
  - StallF = StallD = lwStall || divStall.
  - StallE = divStall.
  - FlushD = PCSrcE && !divStall.
  - FlushE = (lwStall || PCSrcE) && !divStall.
  - StallE overrides FlushE.
- Simultaneous events:
  - PCSrcE together with lwStall: both flushes assert; the PC redirect wins.
  - A divide in EX excludes a load or branch in EX, so lwStall and PCSrcE are 0 while divStall is 1. If a malformed input asserts them anyway, the stall still takes priority.
- Register 0 never forwards and never triggers a stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds three 32-bit outputs: lw_stall_cnt, div_stall_cnt, flush_cnt.
  - Each increments once per cycle its condition holds (lwStall, divStall, FlushD).
  - Each saturates at 0xFFFFFFFF and clears on reset.
- When undefined: the outputs and counters do not exist, and all other behaviour is identical.

Test Plan:
- Forwarding:
  - RegWriteM = 1, rdM = 5, rs1E = 5, RegWriteW = 1, rdW = 5 -> ForwardAE = 10.
  - Drop RegWriteM -> ForwardAE = 01.
  - rdM = rdW = 0 -> ForwardAE = 00.
- Load-use: MemtoRegE = 1, rdE = 7, rs2D = 7 -> StallF = StallD = FlushE = 1 for one cycle, StallE = 0.
- Branch: PCSrcE = 1 -> FlushD = FlushE = 1, no stalls. Same cycle with a lwStall condition -> both flushes = 1, StallF = 1.
- Divide, DIV_LAT = 4: DivOpE held -> StallF/D/E = 1 for cycles 1-3, div_done = 1 only in cycle 4, FSM back in IDLE in cycle 5. Repeat with DIV_LAT = 2 -> 1 stall cycle, then done.
- Reset mid-divide: drop reset during BUSY -> all outputs 0 immediately, state IDLE. After release with DivOpE = 0 -> no div_done.
- HAZARD_PERF_CNT_EN: one DIV_LAT = 4 divide plus two load-use stalls -> div_stall_cnt = 3, lw_stall_cnt = 2.

Source files
------------

// File: rtl/hazard_sched.sv
// Hazard and sequencing controller for the five-stage RV32IM pipeline: forwarding, load-use, redirect and multi-cycle divide.
// Optional stall/flush performance counters are enabled with `define HAZARD_PERF_CNT_EN.

module hazard_fwd (
  input  logic [4:0] rs,
  input  logic [4:0] rdM,
  input  logic       RegWriteM,
  input  logic [4:0] rdW,
  input  logic       RegWriteW,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = 2'b00;
    if (RegWriteM && rdM != 5'd0 && rdM == rs)      fwd = 2'b10;
    else if (RegWriteW && rdW != 5'd0 && rdW == rs) fwd = 2'b01;
  end
endmodule

module hazard_sched #(
  parameter int DIV_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic       MemtoRegE,
  input  logic       DivOpE,
  input  logic       PCSrcE,
  input  logic [4:0] rdM,
  input  logic       RegWriteM,
  input  logic [4:0] rdW,
  input  logic       RegWriteW,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       div_busy,
  output logic       div_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] lw_stall_cnt,
  output logic [31:0] div_stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic lw_stall, div_stall, flush_d;

  logic [NUM_OPS-1:0][4:0] rs_e;
  logic [NUM_OPS-1:0][1:0] fwd;

  assign rs_e = {rs2E, rs1E};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    hazard_fwd u_fwd (
      .rs        (rs_e[i]),
      .rdM       (rdM),
      .RegWriteM (RegWriteM),
      .rdW       (rdW),
      .RegWriteW (RegWriteW),
      .fwd       (fwd[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The entry cycle is spent in IDLE, so the counter covers only the BUSY cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (DivOpE) begin
        cnt_n   = CNT_W'(DIV_LAT - 2);
        state_n = (DIV_LAT == 2) ? DONE : BUSY;
      end
      BUSY: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign lw_stall  = MemtoRegE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
  assign div_stall = (state == IDLE && DivOpE) || state == BUSY;
  assign flush_d   = PCSrcE && !div_stall;

  // Combinational outputs are masked so everything reads 0 while reset is held.
  assign StallF    = reset && (lw_stall || div_stall);
  assign StallD    = reset && (lw_stall || div_stall);
  assign StallE    = reset && div_stall;
  assign FlushD    = reset && flush_d;
  assign FlushE    = reset && (lw_stall || PCSrcE) && !div_stall;
  assign ForwardAE = reset ? fwd[0] : 2'b00;
  assign ForwardBE = reset ? fwd[1] : 2'b00;
  assign div_busy  = reset && div_stall;
  assign div_done  = reset && state == DONE;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lw_stall_cnt  <= '0;
      div_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (lw_stall && lw_stall_cnt != '1)   lw_stall_cnt  <= lw_stall_cnt + 32'd1;
      if (div_stall && div_stall_cnt != '1) div_stall_cnt <= div_stall_cnt + 32'd1;
      if (flush_d && flush_cnt != '1)       flush_cnt     <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: two instances (DIV_LAT 4 and 2) against a cycle-position reference model.
module tb_hazard_sched;
  localparam int LAT_A = 4;
  localparam int LAT_B = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic MemtoRegE, DivOpE, PCSrcE, RegWriteM, RegWriteW;

  logic a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE, a_busy, a_done;
  logic b_StallF, b_StallD, b_StallE, b_FlushD, b_FlushE, b_busy, b_done;
  logic [1:0] a_FwdA, a_FwdB, b_FwdA, b_FwdB;
  logic [10:0] obs_a, obs_b, exp_v;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_lw_cnt, a_div_cnt, a_fl_cnt, b_lw_cnt, b_div_cnt, b_fl_cnt;
`endif

  int checks = 0;
  int fails  = 0;
  int pos_a  = 0;
  int pos_b  = 0;

  always #5 clk = ~clk;

  hazard_sched #(.DIV_LAT(LAT_A), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .MemtoRegE(MemtoRegE), .DivOpE(DivOpE), .PCSrcE(PCSrcE),
    .rdM(rdM), .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW),
    .StallF(a_StallF), .StallD(a_StallD), .StallE(a_StallE), .FlushD(a_FlushD),
    .FlushE(a_FlushE), .ForwardAE(a_FwdA), .ForwardBE(a_FwdB),
    .div_busy(a_busy), .div_done(a_done)
`ifdef HAZARD_PERF_CNT_EN
    , .lw_stall_cnt(a_lw_cnt), .div_stall_cnt(a_div_cnt), .flush_cnt(a_fl_cnt)
`endif
  );

  hazard_sched #(.DIV_LAT(LAT_B), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .MemtoRegE(MemtoRegE), .DivOpE(DivOpE), .PCSrcE(PCSrcE),
    .rdM(rdM), .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW),
    .StallF(b_StallF), .StallD(b_StallD), .StallE(b_StallE), .FlushD(b_FlushD),
    .FlushE(b_FlushE), .ForwardAE(b_FwdA), .ForwardBE(b_FwdB),
    .div_busy(b_busy), .div_done(b_done)
`ifdef HAZARD_PERF_CNT_EN
    , .lw_stall_cnt(b_lw_cnt), .div_stall_cnt(b_div_cnt), .flush_cnt(b_fl_cnt)
`endif
  );

  assign obs_a = {a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE, a_FwdA, a_FwdB, a_busy, a_done};
  assign obs_b = {b_StallF, b_StallD, b_StallE, b_FlushD, b_FlushE, b_FwdA, b_FwdB, b_busy, b_done};

  // Model: pos is the 1-based cycle index of the divide currently in EX (0 = none).
  function automatic int eff(int pos);
    return (pos == 0 && DivOpE) ? 1 : pos;
  endfunction

  function automatic int nxt(int e, int lat);
    return (e == 0 || e == lat) ? 0 : e + 1;
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) begin
      pos_a <= 0;
      pos_b <= 0;
    end else begin
      pos_a <= nxt(eff(pos_a), LAT_A);
      pos_b <= nxt(eff(pos_b), LAT_B);
    end

  function automatic logic [1:0] fwd_ref(logic [4:0] rs);
    if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] expect_out(int pos, int lat);
    int e;
    logic ds, dn, lw;
    e  = eff(pos);
    if (!reset) return '0;
    ds = (e >= 1 && e < lat);
    dn = (e == lat);
    lw = MemtoRegE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    return {lw || ds, lw || ds, ds, PCSrcE && !ds, (lw || PCSrcE) && !ds,
            fwd_ref(rs1E), fwd_ref(rs2E), ds, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {MemtoRegE, DivOpE, PCSrcE, RegWriteM, RegWriteW} = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = {$urandom, $urandom};
      {MemtoRegE, DivOpE, PCSrcE, RegWriteM, RegWriteW} = 5'b11111;
      #4;
      checks++;
      if (obs_a !== 11'd0 || obs_b !== 11'd0) begin
        fails++;
        $display("FAIL reset_outputs: got a=%b b=%b want 0", obs_a, obs_b);
      end
    end
    clear_inputs();
    #2 reset = 1'b1;
  endtask

  task automatic test_forwarding();
    logic [4:0] c_rdm [4] = '{5'd5, 5'd5, 5'd0, 5'd9};
    logic [4:0] c_rdw [4] = '{5'd5, 5'd5, 5'd0, 5'd9};
    logic       c_wm  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] c_exp [4] = '{2'b10, 2'b01, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_inputs();
      rs1E = (i == 3) ? 5'd2 : 5'd5;
      rs2E = (i == 3) ? 5'd9 : 5'd6;
      rdM = c_rdm[i]; rdW = c_rdw[i]; RegWriteM = c_wm[i]; RegWriteW = 1'b1;
      #4;
      checks++;
      if (((i == 3) ? a_FwdB : a_FwdA) !== c_exp[i]) begin
        fails++;
        $display("FAIL fwd_case%0d: got A=%b B=%b want %b", i, a_FwdA, a_FwdB, c_exp[i]);
      end
      exp_v = expect_out(pos_a, LAT_A);
      checks++;
      if (obs_a !== exp_v) begin
        fails++;
        $display("FAIL fwd_model%0d: got %b want %b", i, obs_a, exp_v);
      end
    end
  endtask

  task automatic test_load_use();
    // {StallF,StallD,StallE,FlushD,FlushE}
    logic [4:0] want [4] = '{5'b11001, 5'b00000, 5'b00000, 5'b11001};
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_inputs();
      case (i)
        0: begin MemtoRegE = 1'b1; rdE = 5'd7; rs2D = 5'd7; end
        1: ;
        2: begin MemtoRegE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0; end
        default: begin MemtoRegE = 1'b1; rdE = 5'd31; rs1D = 5'd31; end
      endcase
      #4;
      checks++;
      if ({a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE} !== want[i]) begin
        fails++;
        $display("FAIL load_use%0d: got %b want %b", i,
                 {a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE}, want[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [4:0] want [2] = '{5'b00011, 5'b11011};
    for (int i = 0; i < 2; i++) begin
      tick();
      clear_inputs();
      PCSrcE = 1'b1;
      if (i == 1) begin MemtoRegE = 1'b1; rdE = 5'd4; rs1D = 5'd4; end
      #4;
      checks++;
      if ({a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE} !== want[i]) begin
        fails++;
        $display("FAIL branch%0d: got %b want %b", i,
                 {a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE}, want[i]);
      end
    end
  endtask

  task automatic test_divide();
    logic [4:0] wa, wb;
    tick();
    clear_inputs();
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      DivOpE = (i <= 4);
      #4;
      // {StallF,StallD,StallE,div_busy,div_done}
      wa = (i == 5) ? 5'b00000 : (i < 4) ? 5'b11110 : 5'b00001;
      wb = (i == 5) ? 5'b00000 : (i % 2 == 1) ? 5'b11110 : 5'b00001;
      checks++;
      if ({a_StallF, a_StallD, a_StallE, a_busy, a_done} !== wa) begin
        fails++;
        $display("FAIL div4_cycle%0d: got %b want %b", i,
                 {a_StallF, a_StallD, a_StallE, a_busy, a_done}, wa);
      end
      checks++;
      if ({b_StallF, b_StallD, b_StallE, b_busy, b_done} !== wb) begin
        fails++;
        $display("FAIL div2_cycle%0d: got %b want %b", i,
                 {b_StallF, b_StallD, b_StallE, b_busy, b_done}, wb);
      end
    end
  endtask

  task automatic test_reset_mid_divide();
    tick();
    clear_inputs();
    DivOpE = 1'b1;
    tick();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs_a !== 11'd0 || obs_b !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_div: got a=%b b=%b want 0", obs_a, obs_b);
    end
    DivOpE = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      #4;
      checks++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle%0d: got busy=%b done=%b want 0 0", i, a_busy, a_done);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] eb;
    for (int i = 0; i < 400; i++) begin
      tick();
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
      rdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      if (pos_a != 0) begin
        DivOpE = 1'b1; MemtoRegE = 1'b0; PCSrcE = 1'b0;
      end else begin
        DivOpE    = ($urandom_range(0, 7) == 0);
        MemtoRegE = !DivOpE && ($urandom_range(0, 2) == 0);
        PCSrcE    = !DivOpE && ($urandom_range(0, 3) == 0);
      end
      #4;
      exp_v = expect_out(pos_a, LAT_A);
      eb    = expect_out(pos_b, LAT_B);
      checks++;
      if (obs_a !== exp_v) begin
        fails++;
        $display("FAIL random_a%0d: got %b want %b", i, obs_a, exp_v);
      end
      checks++;
      if (obs_b !== eb) begin
        fails++;
        $display("FAIL random_b%0d: got %b want %b", i, obs_b, eb);
      end
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();
    #2 reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      clear_inputs();
      if (i <= 4) DivOpE = 1'b1;
      else if (i <= 6) begin MemtoRegE = 1'b1; rdE = 5'd3; rs1D = 5'd3; end
    end
    #4;
    checks++;
    if (a_div_cnt !== 32'd3 || a_lw_cnt !== 32'd2 || a_fl_cnt !== 32'd0) begin
      fails++;
      $display("FAIL perf_cnt: got div=%0d lw=%0d flush=%0d want 3 2 0", a_div_cnt, a_lw_cnt, a_fl_cnt);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_divide();
    test_reset_mid_divide();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
